// File: rtl/contor_seq.sv
// contor_seq: streams a two-digit ASCII countdown as tens, units and separator bytes over valid/ready.
// Optional build macro CONTOR_SEQ_LEADZERO_EN drops the tens character while the count is below 10.
module contor_seq #(
    parameter int         STEP     = 1,
    parameter logic [7:0] SEP_CHAR = 8'h0A
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] start_value,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  ascii_out,
    output logic        ascii_valid,
    input  logic        ascii_ready
);
    typedef enum logic [2:0] {IDLE, SEND_T, SEND_U, SEND_S, FINISH} state_t;
    localparam logic [6:0] STEP_V = 7'(STEP);
    state_t     r_state, w_state_next, w_first_start, w_first_dec;
    logic [6:0] r_value, w_value_next, w_start_val, w_dec;
    logic       r_error, w_error_next, w_start_ok;
    logic [3:0] w_tens, w_units;
    assign w_start_ok  = start_value[15:8] >= 8'h30 && start_value[15:8] <= 8'h39 &&
                         start_value[7:0]  >= 8'h30 && start_value[7:0]  <= 8'h39;
    assign w_start_val = 7'(start_value[11:8]) * 7'd10 + 7'(start_value[3:0]);
    assign w_dec       = r_value - STEP_V;
    assign w_tens      = 4'(r_value / 7'd10);
    assign w_units     = 4'(r_value % 7'd10);
`ifdef CONTOR_SEQ_LEADZERO_EN
    // a count below 10 carries no tens character, so its group opens on the units beat
    assign w_first_start = (w_start_val < 7'd10) ? SEND_U : SEND_T;
    assign w_first_dec   = (w_dec < 7'd10) ? SEND_U : SEND_T;
`else
    assign w_first_start = SEND_T;
    assign w_first_dec   = SEND_T;
`endif
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_value <= '0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_value <= w_value_next;
            r_error <= w_error_next;
        end
    end
    always_comb begin
        w_state_next = r_state;
        w_value_next = r_value;
        w_error_next = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && w_start_ok) begin
                    w_state_next = w_first_start;
                    w_value_next = w_start_val;
                end else if (start) begin
                    w_error_next = 1'b1;
                end
            end
            SEND_T: w_state_next = ascii_ready ? SEND_U : SEND_T;
            SEND_U: w_state_next = ascii_ready ? SEND_S : SEND_U;
            SEND_S: begin
                if (ascii_ready && r_value < STEP_V) begin
                    w_state_next = FINISH;
                end else if (ascii_ready) begin
                    w_state_next = w_first_dec;
                    w_value_next = w_dec;
                end
            end
            FINISH:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end
    assign ascii_valid = r_state == SEND_T || r_state == SEND_U || r_state == SEND_S;
    assign ascii_out   = r_state == SEND_T ? {4'h3, w_tens}  :
                         r_state == SEND_U ? {4'h3, w_units} :
                         r_state == SEND_S ? SEP_CHAR        : 8'h00;
    assign busy        = r_state != IDLE;
    assign done        = r_state == FINISH;
    assign error       = r_error;
endmodule

// File: tb/tb_contor_seq.sv
// tb_contor_seq: byte-queue reference model checked every cycle against a STEP=1 and a STEP=3 instance.
module tb_contor_seq;
    localparam logic [7:0] SEP = 8'h0A;
`ifdef CONTOR_SEQ_LEADZERO_EN
    localparam int N20 = 53, N03 = 8, N00 = 2, N01 = 4, N10S3 = 9;
`else
    localparam int N20 = 63, N03 = 12, N00 = 3, N01 = 6, N10S3 = 12;
`endif
    logic        clock = 1'b0;
    logic        reset [2];
    logic        start [2];
    logic [15:0] start_value [2];
    logic        ascii_ready [2];
    logic        busy [2], done [2], error [2], ascii_valid [2];
    logic [7:0]  ascii_out [2];
    logic [7:0]  q [2][$];
    logic [7:0]  got [$];
    bit          m_busy [2], m_done [2], m_err [2];
    bit          prev_stall [2];
    logic [7:0]  prev_out [2];
    int          xfers [2], dones [2], errs [2];
    int          total = 0, bad = 0;
    bit          chk = 1'b0;
    always #5 clock = ~clock;

    contor_seq #(.STEP(1), .SEP_CHAR(SEP)) dut1 (
        .clock(clock), .reset(reset[0]), .start(start[0]), .start_value(start_value[0]),
        .busy(busy[0]), .done(done[0]), .error(error[0]), .ascii_out(ascii_out[0]),
        .ascii_valid(ascii_valid[0]), .ascii_ready(ascii_ready[0]));
    contor_seq #(.STEP(3), .SEP_CHAR(SEP)) dut3 (
        .clock(clock), .reset(reset[1]), .start(start[1]), .start_value(start_value[1]),
        .busy(busy[1]), .done(done[1]), .error(error[1]), .ascii_out(ascii_out[1]),
        .ascii_valid(ascii_valid[1]), .ascii_ready(ascii_ready[1]));

    function automatic bit is_dig(logic [7:0] b);
        return b >= 8'h30 && b <= 8'h39;
    endfunction

    task automatic cmp(string nm, logic [15:0] act, logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // whole expected byte stream of one run, derived from the countdown rules
    task automatic fill(input int i, input int v, input int step);
        for (int g = v; g >= 0; g -= step) begin
`ifdef CONTOR_SEQ_LEADZERO_EN
            if (g >= 10) q[i].push_back(8'(48 + g / 10));
`else
            q[i].push_back(8'(48 + g / 10));
`endif
            q[i].push_back(8'(48 + g % 10));
            q[i].push_back(SEP);
        end
    endtask

    initial forever begin
        @(posedge clock);
        for (int i = 0; i < 2; i++) begin
            bit pd;
            pd = m_done[i];
            if (reset[i]) begin
                q[i].delete();
                m_busy[i] = 1'b0;
                m_done[i] = 1'b0;
                m_err[i]  = 1'b0;
            end else begin
                m_done[i] = 1'b0;
                m_err[i]  = 1'b0;
                if (q[i].size() > 0) begin
                    if (ascii_ready[i]) begin
                        void'(q[i].pop_front());
                        if (q[i].size() == 0) m_done[i] = 1'b1;
                    end
                end else if (pd) begin
                    m_busy[i] = 1'b0;
                end else if (!m_busy[i] && start[i]) begin
                    if (is_dig(start_value[i][15:8]) && is_dig(start_value[i][7:0])) begin
                        fill(i, (int'(start_value[i][15:8]) - 48) * 10 + int'(start_value[i][7:0]) - 48, i == 0 ? 1 : 3);
                        m_busy[i] = 1'b1;
                    end else begin
                        m_err[i] = 1'b1;
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clock);
        if (chk) for (int i = 0; i < 2; i++) begin
            bit       ev;
            logic [7:0] eo;
            ev = q[i].size() > 0;
            eo = ev ? q[i][0] : 8'h00;
            cmp($sformatf("valid%0d", i), 16'(ascii_valid[i]), 16'(ev));
            cmp($sformatf("out%0d", i), 16'(ascii_out[i]), 16'(eo));
            cmp($sformatf("busy%0d", i), 16'(busy[i]), 16'(m_busy[i]));
            cmp($sformatf("done%0d", i), 16'(done[i]), 16'(m_done[i]));
            cmp($sformatf("error%0d", i), 16'(error[i]), 16'(m_err[i]));
            if (prev_stall[i]) cmp($sformatf("hold%0d", i), {ascii_valid[i], 7'd0, ascii_out[i]}, {1'b1, 7'd0, prev_out[i]});
            prev_stall[i] = ascii_valid[i] === 1'b1 && !ascii_ready[i] && !reset[i];
            prev_out[i]   = ascii_out[i];
            if (ascii_valid[i] === 1'b1 && ascii_ready[i]) begin
                xfers[i]++;
                if (i == 0) got.push_back(ascii_out[i]);
            end
            if (done[i] === 1'b1) dones[i]++;
            if (error[i] === 1'b1) errs[i]++;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cmd(input int i, input logic [15:0] v);
        start[i] = 1'b1;
        start_value[i] = v;
        tick();
        start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int limit, input string nm);
        int n;
        n = 0;
        while (done[i] !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        total++;
        if (done[i] !== 1'b1) begin
            bad++;
            $display("FAIL %s: done not seen within %0d cycles", nm, limit);
        end
    endtask

    task automatic outs_zero(input int i, input string nm);
        cmp(nm, {3'b0, busy[i], done[i], error[i], ascii_valid[i], 1'b0, ascii_out[i]}, 16'h0000);
    endtask

    initial begin
        int x0, d0, e0, n, stall;
        bit grp;
        for (int i = 0; i < 2; i++) begin
            reset[i] = 1'b1;
            start[i] = 1'b0;
            start_value[i] = 16'h0;
            ascii_ready[i] = 1'b1;
        end
        tick();
        chk = 1'b1;
        tick();
        outs_zero(0, "reset_state");
        reset[0] = 1'b0;
        reset[1] = 1'b0;
        tick();
        outs_zero(1, "idle_state");

        got.delete(); x0 = xfers[0]; d0 = dones[0];
        cmd(0, "20");
        cmp("run20_busy", 16'(busy[0]), 16'd1);
        wait_done(0, 200, "run20");
        tick();
        cmp("run20_bytes", 16'(xfers[0] - x0), 16'(N20));
        cmp("run20_first", {got[0], got[1]}, "20");
        cmp("run20_last", {got[got.size() - 2], got[got.size() - 1]}, {8'h30, SEP});
        cmp("run20_dones", 16'(dones[0] - d0), 16'd1);

        got.delete(); x0 = xfers[0];
        cmd(0, "03");
        grp = 1'b1; stall = 0; n = 0;
        while (done[0] !== 1'b1 && n < 200) begin
            if (ascii_valid[0] && grp && stall < 4) begin
                ascii_ready[0] = 1'b0;
                stall++;
            end else begin
                ascii_ready[0] = 1'b1;
                if (ascii_valid[0]) begin
                    grp = ascii_out[0] == SEP;
                    stall = 0;
                end
            end
            tick();
            n++;
        end
        ascii_ready[0] = 1'b1;
        cmp("bp_done", 16'(done[0]), 16'd1);
        tick();
        cmp("bp_bytes", 16'(xfers[0] - x0), 16'(N03));
`ifdef CONTOR_SEQ_LEADZERO_EN
        cmp("bp_first", {got[0], got[1]}, {8'h33, SEP});
`else
        cmp("bp_first", {got[0], got[1]}, "03");
`endif

        e0 = errs[0];
        cmd(0, "2A");
        cmp("err_2A", {14'd0, error[0], busy[0] | ascii_valid[0]}, 16'd2);
        tick();
        cmd(0, 16'h3A30);
        cmp("err_3A30", {14'd0, error[0], busy[0] | ascii_valid[0]}, 16'd2);
        tick();
        cmp("err_count", 16'(errs[0] - e0), 16'd2);

        x0 = xfers[0]; d0 = dones[0];
        cmd(0, "00");
        cmd(0, "99");
        wait_done(0, 50, "run00");
        cmd(0, "99");
        cmp("done_start_ignored", 16'(busy[0]), 16'd0);
        cmd(0, "01");
        cmp("restart_busy", 16'(busy[0]), 16'd1);
        wait_done(0, 50, "run01");
        tick();
        cmp("run00_01_bytes", 16'(xfers[0] - x0), 16'(N00 + N01));
        cmp("run00_01_dones", 16'(dones[0] - d0), 16'd2);

        x0 = xfers[0];
        cmd(0, "20");
        n = 0;
        while (xfers[0] - x0 < 7 && n < 100) begin
            tick();
            n++;
        end
        reset[0] = 1'b1;
        ascii_ready[0] = 1'b0;
        tick();
        outs_zero(0, "midreset_outs");
        reset[0] = 1'b0;
        ascii_ready[0] = 1'b1;
        d0 = dones[0];
        repeat (3) tick();
        cmp("midreset_bytes", 16'(xfers[0] - x0), 16'd7);
        cmp("midreset_nodone", 16'(dones[0] - d0), 16'd0);
        x0 = xfers[0];
        cmd(0, "01");
        wait_done(0, 50, "after_reset01");
        tick();
        cmp("after_reset01_bytes", 16'(xfers[0] - x0), 16'(N01));

        x0 = xfers[1];
        cmd(1, "10");
        wait_done(1, 50, "step3_run10");
        tick();
        cmp("step3_bytes", 16'(xfers[1] - x0), 16'(N10S3));

        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                ascii_ready[i] = $urandom_range(0, 3) != 0;
                reset[i] = $urandom_range(0, 399) == 0;
                start[i] = $urandom_range(0, 7) == 0;
                start_value[i] = $urandom_range(0, 3) != 0 ?
                    {8'(8'h30 + $urandom_range(0, 9)), 8'(8'h30 + $urandom_range(0, 9))} : 16'($urandom);
            end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            reset[i] = 1'b0;
            start[i] = 1'b0;
            ascii_ready[i] = 1'b1;
        end
        repeat (400) tick();
        outs_zero(0, "drain0");
        outs_zero(1, "drain1");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
